// File: rtl/icache_pkg.sv
// Shared types and width helpers for the prefetching instruction cache.
// Geometry widths are derived from the top-level parameters through these functions.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        PF_BUSY  = 2'd2,
        PF_DRAIN = 2'd3
    } state_e;

    // Widest line the word-select helper accepts; narrower lines are zero-extended.
    localparam int MAX_LINE_WORDS = 64;
    typedef logic [32*MAX_LINE_WORDS-1:0] wide_line_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int la_w(input int addr_w, input int line_words);
        return addr_w - off_w(line_words);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_words, input int sets);
        return la_w(addr_w, line_words) - idx_w(sets);
    endfunction

    function automatic logic [31:0] word_sel(input wide_line_t line, input logic [5:0] off);
        return line[{off, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/icache_prefetch_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The cache uses the slave view; the fetch stage and memory model use the master view.
interface icache_prefetch_if #(
    parameter int ADDR_W     = 30,
    parameter int LINE_WORDS = 4
);
    localparam int LA_W = ADDR_W - $clog2(LINE_WORDS);

    logic                    proc_read;
    logic                    proc_write;
    logic [ADDR_W-1:0]       proc_addr;
    logic [31:0]             proc_wdata;
    logic                    proc_stall;
    logic [31:0]             proc_rdata;
    logic                    mem_read;
    logic                    mem_write;
    logic [LA_W-1:0]         mem_addr;
    logic [32*LINE_WORDS-1:0] mem_wdata;
    logic                    mem_ready;
    logic [32*LINE_WORDS-1:0] mem_rdata;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/icache_way_array.sv
// One cache way: per-set valid bit, tag and line storage with a combinational
// tag compare on the read side and a single synchronous write port.
module icache_way_array
    import icache_pkg::*;
#(
    parameter int SETS   = 4,
    parameter int TAG_W  = 26,
    parameter int LINE_W = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [idx_w(SETS)-1:0]   rd_idx,
    input  logic [TAG_W-1:0]         rd_tag,
    output logic                     hit,
    output logic [LINE_W-1:0]        rd_line,
    input  logic                     we,
    input  logic [idx_w(SETS)-1:0]   wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [LINE_W-1:0]        wr_line
);

    logic [SETS-1:0]   valid_r;
    logic [TAG_W-1:0]  tag_r  [SETS];
    logic [LINE_W-1:0] data_r [SETS];

    // Valid bits are the only reset state of a way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (we) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and line storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_line;
        end
    end

    assign hit     = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
    assign rd_line = data_r[rd_idx];

endmodule

// File: rtl/icache_prefetch.sv
// N-way set-associative read-only instruction cache with round-robin replacement
// and a one-line stream buffer fed by next-line prefetches.
module icache_prefetch
    import icache_pkg::*;
#(
    parameter int ADDR_W      = 30,
    parameter int WAYS        = 2,
    parameter int SETS        = 4,
    parameter int LINE_WORDS  = 4,
    parameter int PREFETCH_EN = 1
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    icache_prefetch_if.slave  bus
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_WORDS, SETS);
    localparam int LA_W   = la_w(ADDR_W, LINE_WORDS);
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam bit PF_ON  = (PREFETCH_EN != 32'sd0);

    state_e              state_r, state_nx_s;
    logic [LA_W-1:0]     line_s, fill_addr_r, pf_addr_r, sb_addr_r, pf_next_s, wr_addr_s;
    logic [IDX_W-1:0]    idx_s, wr_idx_s;
    logic [TAG_W-1:0]    tag_s, wr_tag_s;
    logic [5:0]          off_s;
    logic [WAYS-1:0]     way_hit_s;
    logic [LINE_W-1:0]   way_line_s [WAYS];
    logic [LINE_W-1:0]   hit_line_s, sb_data_r, wr_line_s;
    logic [RR_W-1:0]     rr_r [SETS];
    logic [RR_W-1:0]     victim_s, rr_next_s;
    logic                hit_any_s, hit_s, sb_hit_s, demand_miss_s, issue_pf_s, pf_miss_s, pf_match_s;
    logic                sb_valid_r, pf_pend_r;
    logic                stall_s, mem_read_s, wr_en_s, wr_from_sb_s;
    logic                sb_load_s, sb_clear_s, pf_set_s, pf_clear_s, fill_cap_s;
    logic [31:0]         rdata_s;
    logic [LA_W-1:0]     mem_addr_s;
    logic                unused_s;

    assign line_s = bus.proc_addr[ADDR_W-1:OFF_W];
    assign idx_s  = bus.proc_addr[OFF_W+IDX_W-1:OFF_W];
    assign tag_s  = bus.proc_addr[ADDR_W-1:OFF_W+IDX_W];
    assign off_s  = 6'(bus.proc_addr[OFF_W-1:0]);

    assign wr_idx_s  = wr_addr_s[IDX_W-1:0];
    assign wr_tag_s  = wr_addr_s[LA_W-1:IDX_W];
    assign wr_line_s = wr_from_sb_s ? sb_data_r : bus.mem_rdata;
    assign victim_s  = rr_r[wr_idx_s];
    assign rr_next_s = (WAYS > 1) ? victim_s + RR_W'(1) : RR_W'(0);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way_array #(
            .SETS   (SETS),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W)
        ) u_way (
            .clk     (clk),
            .rst_n   (proc_reset_n),
            .rd_idx  (idx_s),
            .rd_tag  (tag_s),
            .hit     (way_hit_s[w]),
            .rd_line (way_line_s[w]),
            .we      (wr_en_s && (victim_s == RR_W'(w))),
            .wr_idx  (wr_idx_s),
            .wr_tag  (wr_tag_s),
            .wr_line (wr_line_s)
        );
    end

    // Lowest-numbered hitting way wins should several ever match.
    always_comb begin
        hit_line_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_line_s = way_hit_s[w] ? way_line_s[w] : hit_line_s;
        end
    end

    assign hit_any_s     = |way_hit_s;
    assign hit_s         = bus.proc_read && hit_any_s;
    assign sb_hit_s      = PF_ON && bus.proc_read && sb_valid_r && (sb_addr_r == line_s) && !hit_any_s;
    assign demand_miss_s = bus.proc_read && !hit_any_s && !sb_hit_s;
    assign issue_pf_s    = PF_ON && pf_pend_r && !demand_miss_s && !sb_hit_s;
    assign pf_miss_s     = bus.proc_read && !hit_any_s;
    assign pf_match_s    = (line_s == pf_addr_r);

    // State register.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; every memory request runs to its mem_ready before IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:     state_nx_s = demand_miss_s ? FILL : (issue_pf_s ? PF_BUSY : IDLE);
            FILL:     state_nx_s = bus.mem_ready ? IDLE : FILL;
            PF_BUSY: begin
                if (bus.mem_ready) begin
                    state_nx_s = IDLE;
                end else if (pf_miss_s && !pf_match_s) begin
                    state_nx_s = PF_DRAIN;
                end else begin
                    state_nx_s = PF_BUSY;
                end
            end
            PF_DRAIN: state_nx_s = bus.mem_ready ? IDLE : PF_DRAIN;
            default:  state_nx_s = IDLE;
        endcase
    end

    // Output and datapath-control decode.
    always_comb begin
        stall_s      = 1'b0;
        rdata_s      = 32'd0;
        mem_read_s   = 1'b0;
        mem_addr_s   = '0;
        wr_en_s      = 1'b0;
        wr_addr_s    = line_s;
        wr_from_sb_s = 1'b0;
        sb_load_s    = 1'b0;
        sb_clear_s   = 1'b0;
        pf_set_s     = 1'b0;
        pf_next_s    = '0;
        pf_clear_s   = 1'b0;
        fill_cap_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (demand_miss_s) begin
                    stall_s    = 1'b1;
                    mem_read_s = 1'b1;
                    mem_addr_s = line_s;
                    fill_cap_s = 1'b1;
                    sb_clear_s = (sb_addr_r == line_s);
                end else if (sb_hit_s) begin
                    rdata_s      = word_sel(wide_line_t'(sb_data_r), off_s);
                    wr_en_s      = 1'b1;
                    wr_addr_s    = sb_addr_r;
                    wr_from_sb_s = 1'b1;
                    sb_clear_s   = 1'b1;
                    pf_set_s     = 1'b1;
                    pf_next_s    = sb_addr_r + LA_W'(1);
                end else begin
                    rdata_s    = hit_s ? word_sel(wide_line_t'(hit_line_s), off_s) : 32'd0;
                    mem_read_s = issue_pf_s;
                    mem_addr_s = issue_pf_s ? pf_addr_r : '0;
                    pf_clear_s = issue_pf_s;
                end
            end
            FILL: begin
                mem_read_s = 1'b1;
                mem_addr_s = fill_addr_r;
                if (bus.mem_ready) begin
                    rdata_s   = word_sel(wide_line_t'(bus.mem_rdata), off_s);
                    wr_en_s   = 1'b1;
                    wr_addr_s = fill_addr_r;
                    pf_set_s  = 1'b1;
                    pf_next_s = fill_addr_r + LA_W'(1);
                end else begin
                    stall_s = 1'b1;
                end
            end
            PF_BUSY: begin
                mem_read_s = 1'b1;
                mem_addr_s = pf_addr_r;
                if (pf_miss_s && pf_match_s) begin
                    stall_s   = !bus.mem_ready;
                    rdata_s   = bus.mem_ready ? word_sel(wide_line_t'(bus.mem_rdata), off_s) : 32'd0;
                    wr_en_s   = bus.mem_ready;
                    wr_addr_s = pf_addr_r;
                    pf_set_s  = bus.mem_ready;
                    pf_next_s = pf_addr_r + LA_W'(1);
                end else if (pf_miss_s) begin
                    stall_s   = 1'b1;
                    sb_load_s = bus.mem_ready;
                end else begin
                    rdata_s   = hit_s ? word_sel(wide_line_t'(hit_line_s), off_s) : 32'd0;
                    sb_load_s = bus.mem_ready;
                end
            end
            PF_DRAIN: begin
                stall_s    = 1'b1;
                mem_read_s = 1'b1;
                mem_addr_s = pf_addr_r;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
    end

    // Stream buffer, prefetch bookkeeping and round-robin pointers.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            sb_valid_r  <= 1'b0;
            pf_pend_r   <= 1'b0;
            pf_addr_r   <= '0;
            fill_addr_r <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_r[s] <= '0;
            end
        end else begin
            if (sb_load_s) begin
                sb_valid_r <= 1'b1;
            end else if (sb_clear_s) begin
                sb_valid_r <= 1'b0;
            end
            if (pf_set_s) begin
                pf_pend_r <= PF_ON;
                pf_addr_r <= pf_next_s;
            end else if (pf_clear_s) begin
                pf_pend_r <= 1'b0;
            end
            if (fill_cap_s) begin
                fill_addr_r <= line_s;
            end
            if (wr_en_s) begin
                rr_r[wr_idx_s] <= rr_next_s;
            end
        end
    end

    // Stream-buffer payload, only meaningful while sb_valid_r is set.
    always_ff @(posedge clk) begin
        if (sb_load_s) begin
            sb_addr_r <= pf_addr_r;
            sb_data_r <= bus.mem_rdata;
        end
    end

    // Outputs read as zero for as long as reset is asserted.
    assign bus.proc_stall = proc_reset_n && stall_s;
    assign bus.proc_rdata = proc_reset_n ? rdata_s : 32'd0;
    assign bus.mem_read   = proc_reset_n && mem_read_s;
    assign bus.mem_addr   = proc_reset_n ? mem_addr_s : '0;
    assign bus.mem_write  = 1'b0;
    assign bus.mem_wdata  = '0;
    assign unused_s       = ^{bus.proc_write, bus.proc_wdata};

endmodule

// File: tb/tb_icache_prefetch.sv
// Directed vector bench for icache_prefetch: a per-cycle table of inputs and
// expected outputs, then hand-written address-wrap and mid-fill reset sequences.
module tb_icache_prefetch;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    icache_prefetch_if #(.ADDR_W(30), .LINE_WORDS(4)) bus ();

    icache_prefetch #(
        .ADDR_W      (30),
        .WAYS        (2),
        .SETS        (4),
        .LINE_WORDS  (4),
        .PREFETCH_EN (1)
    ) dut (
        .clk          (clk),
        .proc_reset_n (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [29:0] addr;
        logic        rdy;
        logic [27:0] mline;
        logic        stall;
        logic        mrd;
        logic [27:0] maddr;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mkword(input logic [27:0] la, input int w);
        return (32'(la) << 4) ^ 32'h5A00_0000 ^ 32'(w);
    endfunction

    function automatic logic [127:0] mkline(input logic [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = mkword(la, w);
        return l;
    endfunction

    function automatic vec_t mk(input logic rd, input logic [29:0] addr, input logic rdy,
                                input logic [27:0] mline, input logic stall, input logic mrd,
                                input logic [27:0] maddr);
        vec_t v;
        v.rd = rd; v.addr = addr; v.rdy = rdy; v.mline = mline;
        v.stall = stall; v.mrd = mrd; v.maddr = maddr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        bus.proc_read = v.rd;
        bus.proc_addr = v.addr;
        bus.mem_ready = v.rdy;
        bus.mem_rdata = v.rdy ? mkline(v.mline) : 128'd0;
        #1;
        chk({tag, " stall"}, 32'(bus.proc_stall), 32'(v.stall));
        chk({tag, " mem_read"}, 32'(bus.mem_read), 32'(v.mrd));
        chk({tag, " mem_write"}, 32'(bus.mem_write), 32'd0);
        if (v.mrd) chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(v.maddr));
        if (v.rd && !v.stall) chk({tag, " rdata"}, bus.proc_rdata, mkword(v.addr[29:2], int'(v.addr[1:0])));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " stall"}, 32'(bus.proc_stall), 32'd0);
        chk({tag, " mem_read"}, 32'(bus.mem_read), 32'd0);
        chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, " rdata"}, bus.proc_rdata, 32'd0);
        chk({tag, " mem_write"}, 32'(bus.mem_write), 32'd0);
        chk({tag, " mem_wdata"}, 32'(|bus.mem_wdata), 32'd0);
    endtask

    initial begin
        // rd, addr, rdy, mline, stall, mrd, maddr  -- one row per clock
        // Cold miss on line 0, fill, next-line prefetch of line 1
        vq.push_back(mk(1'b1, 30'h000, 1'b0, 28'h0, 1'b1, 1'b1, 28'h0));
        vq.push_back(mk(1'b1, 30'h000, 1'b0, 28'h0, 1'b1, 1'b1, 28'h0));
        vq.push_back(mk(1'b1, 30'h000, 1'b0, 28'h0, 1'b1, 1'b1, 28'h0));
        vq.push_back(mk(1'b1, 30'h000, 1'b1, 28'h0, 1'b0, 1'b1, 28'h0));
        vq.push_back(mk(1'b0, 30'h000, 1'b0, 28'h0, 1'b0, 1'b1, 28'h1));
        vq.push_back(mk(1'b0, 30'h000, 1'b0, 28'h0, 1'b0, 1'b1, 28'h1));
        vq.push_back(mk(1'b0, 30'h000, 1'b1, 28'h1, 1'b0, 1'b1, 28'h1));
        // Stream-buffer hit on line 1, chained prefetch of line 2, cache re-hits
        vq.push_back(mk(1'b1, 30'h006, 1'b0, 28'h0, 1'b0, 1'b0, 28'h0));
        vq.push_back(mk(1'b0, 30'h000, 1'b0, 28'h0, 1'b0, 1'b1, 28'h2));
        vq.push_back(mk(1'b1, 30'h006, 1'b0, 28'h0, 1'b0, 1'b1, 28'h2));
        vq.push_back(mk(1'b1, 30'h000, 1'b0, 28'h0, 1'b0, 1'b1, 28'h2));
        vq.push_back(mk(1'b0, 30'h000, 1'b1, 28'h2, 1'b0, 1'b1, 28'h2));
        vq.push_back(mk(1'b1, 30'h008, 1'b0, 28'h0, 1'b0, 1'b0, 28'h0));
        // Demand read of the line being prefetched (line 3): no second request
        vq.push_back(mk(1'b0, 30'h000, 1'b0, 28'h0, 1'b0, 1'b1, 28'h3));
        vq.push_back(mk(1'b1, 30'h00D, 1'b0, 28'h0, 1'b1, 1'b1, 28'h3));
        vq.push_back(mk(1'b1, 30'h00D, 1'b0, 28'h0, 1'b1, 1'b1, 28'h3));
        vq.push_back(mk(1'b1, 30'h00D, 1'b1, 28'h3, 1'b0, 1'b1, 28'h3));
        vq.push_back(mk(1'b1, 30'h00D, 1'b0, 28'h0, 1'b0, 1'b1, 28'h4));
        // Unrelated miss during prefetch of line 4: drain, then fill line 8
        vq.push_back(mk(1'b1, 30'h020, 1'b0, 28'h0, 1'b1, 1'b1, 28'h4));
        vq.push_back(mk(1'b1, 30'h020, 1'b0, 28'h0, 1'b1, 1'b1, 28'h4));
        vq.push_back(mk(1'b1, 30'h020, 1'b1, 28'h4, 1'b1, 1'b1, 28'h4));
        vq.push_back(mk(1'b1, 30'h020, 1'b0, 28'h0, 1'b1, 1'b1, 28'h8));
        vq.push_back(mk(1'b1, 30'h020, 1'b1, 28'h8, 1'b0, 1'b1, 28'h8));
        vq.push_back(mk(1'b0, 30'h000, 1'b0, 28'h0, 1'b0, 1'b1, 28'h9));
        vq.push_back(mk(1'b0, 30'h000, 1'b1, 28'h9, 1'b0, 1'b1, 28'h9));
        // Round robin in set 0: line 4 evicts line 0, line 8 still hits, line 0 misses
        vq.push_back(mk(1'b1, 30'h010, 1'b0, 28'h0, 1'b1, 1'b1, 28'h4));
        vq.push_back(mk(1'b1, 30'h010, 1'b1, 28'h4, 1'b0, 1'b1, 28'h4));
        vq.push_back(mk(1'b1, 30'h020, 1'b0, 28'h0, 1'b0, 1'b1, 28'h5));
        vq.push_back(mk(1'b1, 30'h000, 1'b0, 28'h0, 1'b1, 1'b1, 28'h5));
        vq.push_back(mk(1'b1, 30'h000, 1'b1, 28'h5, 1'b1, 1'b1, 28'h5));
        vq.push_back(mk(1'b1, 30'h000, 1'b0, 28'h0, 1'b1, 1'b1, 28'h0));
        vq.push_back(mk(1'b1, 30'h000, 1'b1, 28'h0, 1'b0, 1'b1, 28'h0));
        vq.push_back(mk(1'b1, 30'h010, 1'b0, 28'h0, 1'b0, 1'b1, 28'h1));
        vq.push_back(mk(1'b0, 30'h000, 1'b1, 28'h1, 1'b0, 1'b1, 28'h1));
        // mem_ready while idle is ignored: line 7 still misses afterwards
        vq.push_back(mk(1'b0, 30'h000, 1'b1, 28'h7, 1'b0, 1'b0, 28'h0));
        vq.push_back(mk(1'b1, 30'h01C, 1'b0, 28'h0, 1'b1, 1'b1, 28'h7));
        vq.push_back(mk(1'b1, 30'h01C, 1'b1, 28'h7, 1'b0, 1'b1, 28'h7));
        vq.push_back(mk(1'b0, 30'h000, 1'b0, 28'h0, 1'b0, 1'b1, 28'h8));
        vq.push_back(mk(1'b0, 30'h000, 1'b1, 28'h8, 1'b0, 1'b1, 28'h8));

        rst_n          = 1'b0;
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b0;
        bus.proc_addr  = 30'h0;
        bus.proc_wdata = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 128'd0;
        #1;
        chk_zero("reset");
        bus.proc_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i], $sformatf("row%0d", i));
        end

        // Top-of-memory line wraps its next-line prefetch to line 0
        step(mk(1'b1, 30'h3FFF_FFFF, 1'b0, 28'h0,         1'b1, 1'b1, 28'hFFF_FFFF), "wrap0");
        step(mk(1'b1, 30'h3FFF_FFFF, 1'b1, 28'hFFF_FFFF,  1'b0, 1'b1, 28'hFFF_FFFF), "wrap1");
        step(mk(1'b0, 30'h0,         1'b0, 28'h0,         1'b0, 1'b1, 28'h0),        "wrap2");
        step(mk(1'b0, 30'h0,         1'b1, 28'h0,         1'b0, 1'b1, 28'h0),        "wrap3");

        // Asynchronous reset in the middle of a fill
        step(mk(1'b1, 30'h040, 1'b0, 28'h0, 1'b1, 1'b1, 28'h10), "rst0");
        step(mk(1'b1, 30'h040, 1'b0, 28'h0, 1'b1, 1'b1, 28'h10), "rst1");
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("midfill_reset");
        @(negedge clk);
        bus.proc_read = 1'b0;
        rst_n = 1'b1;
        step(mk(1'b1, 30'h000, 1'b0, 28'h0, 1'b1, 1'b1, 28'h0), "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_prefetch.md
Name: icache_prefetch

Overview:
Parametrised read-only instruction cache between the fetch stage and the line-wide instruction memory. It is N-way set-associative with round-robin replacement. A one-line stream buffer issues a next-line prefetch after every demand fill and after every stream-buffer hit. It replaces the fixed 2-way, 4-set, 4-word-line icache in the baseline core.

Parameters:
ADDR_W, 30, processor word-address width
WAYS, 2, associativity (power of 2, >=1)
SETS, 4, number of sets (power of 2, >=2)
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)
PREFETCH_EN, 1, 0 disables the stream buffer and all prefetch requests

Ports:
clk  in  1  clock, rising edge
proc_reset_n  in  1  asynchronous, active-low reset
proc_read  in  1  fetch request, held until stall is low
proc_write  in  1  ignored (read-only cache)
proc_addr  in  ADDR_W  word address: [OFF_W-1:0] word, [OFF_W+IDX_W-1:OFF_W] set, rest tag
proc_wdata  in  32  ignored
proc_stall  out  1  fetch must hold
proc_rdata  out  32  instruction, valid when proc_read=1 and proc_stall=0
mem_read  out  1  line read request, held until mem_ready
mem_write  out  1  tied 0
mem_addr  out  LA_W  line address (LA_W = ADDR_W-OFF_W), stable while mem_read=1
mem_wdata  out  32*LINE_WORDS  tied 0
mem_ready  in  1  one-cycle pulse; mem_rdata valid in that cycle
mem_rdata  in  32*LINE_WORDS  line data, word0 in [31:0]

Behaviour:
- OFF_W=log2(LINE_WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-OFF_W-IDX_W.
- Reset (async assert): all outputs 0, all valid bits 0, stream buffer invalid, round-robin pointers 0, state IDLE. Data and tag arrays are not reset.
- The hit path is combinational, with 0-cycle latency.
  - Cache hit in IDLE or PF_BUSY: proc_rdata = hit way word, proc_stall=0.
  - Multiple-way hit cannot occur; if it does, the lowest way wins.
- Stream-buffer hit (sb_valid && sb_addr == line(proc_addr)) with no cache hit:
  - 0-cycle data return; the line is installed into the victim way at the next edge.
  - The set's pointer increments and sb_valid clears.
  - A new prefetch of sb_addr+1 is issued.
- States: IDLE, FILL, PF_BUSY, PF_DRAIN.
- IDLE:
  - Miss in both cache and stream buffer: proc_stall=1, mem_read=1, mem_addr=line(proc_addr); go to FILL.
  - Otherwise, if a prefetch is pending and PREFETCH_EN: mem_read=1, mem_addr=pf_addr; go to PF_BUSY.
- FILL: hold mem_read/mem_addr and proc_stall=1. On mem_ready:
  - Forward the selected word; proc_stall=0 in that cycle.
  - Write the line to the victim way (valid=1, tag) and increment the pointer.
  - Set pending prefetch pf_addr = line+1; go to IDLE.
- PF_BUSY: hold mem_read, mem_addr=pf_addr. Cache hits are served normally.
  - Miss with line(proc_addr)==pf_addr: proc_stall=1 until mem_ready, then forward the word and install the line directly in the cache. Pending prefetch becomes pf_addr+1; go to IDLE.
  - Miss to any other line: proc_stall=1; go to PF_DRAIN.
  - mem_ready with no miss: load the stream buffer (sb_valid=1); go to IDLE.
- PF_DRAIN: proc_stall=1, hold the prefetch request. On mem_ready, discard the data and go to IDLE, which starts the demand fill next cycle.
- A request is never abandoned: mem_addr changes only in the cycle after mem_ready.
- Line address increment wraps modulo 2^LA_W (all-ones+1 = 0).
- mem_ready in IDLE is ignored.
- A demand fill of a line equal to sb_addr invalidates the stream buffer.
- proc_read=0: no state change except prefetch progress.

Decomposition:
- Package icache_pkg holds:
  - state enum (IDLE, FILL, PF_BUSY, PF_DRAIN);
  - functions/localparams for OFF_W, IDX_W, TAG_W, LA_W;
  - word-select helper.
- One sub-module, icache_way_array: valid, tag and data storage for one way, with a combinational tag compare and a write port. It is instantiated WAYS times in a generate loop.
- The top level keeps the FSM, round-robin pointers and stream buffer.

Test Plan:
1. Reset, read 0x000 -> stall=1, mem_read=1, mem_addr=0x0. mem_ready on cycle 3 with words A0..A3 -> proc_rdata=A0 and stall=0 that cycle. Next cycle mem_read=1, mem_addr=0x1.
2. After scenario 1, let the prefetch complete with B0..B3, then read 0x006 -> rdata=B2 with stall=0. Next cycle mem_addr=0x2 (chained prefetch). Re-read of 0x006 hits in the cache.
3. Read 0x005 while the prefetch of line 0x1 is outstanding -> stall until mem_ready, then rdata=word1. No second request for line 0x1.
4. Read 0x020 while the prefetch of 0x1 is outstanding -> stall through prefetch completion (discarded), then mem_addr=0x8 fill, then rdata correct.
5. Defaults, reads 0x000, 0x010, 0x020 (same set 0) -> third fill evicts way0 (round-robin). Read 0x000 misses, 0x010 hits.
6. Read 0x3FFFFFFF miss -> fill line 0xFFFFFFF, then prefetch mem_addr=0x0. Assert proc_reset_n=0 mid-FILL -> all outputs 0 immediately. After release, a read of 0x000 misses.
